sha3_feed_controller: RTL and testbench
=======================================

SHA3_FEED_CONTROLLER -- requirements
Module: sha3_feed_controller

Interface
REQ-001 Parameter LEN_W, default 16, width of message-length field in bytes.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to hash one message; sampled only in IDLE.
REQ-005 msg_len  input  LEN_W  message length in bytes; sampled with accepted start.
REQ-006 busy  output  1  high in every state except IDLE.
REQ-007 s_data  input  64  message word, little-endian bytes.
REQ-008 s_valid  input  1  s_data valid.
REQ-009 s_ready  output  1  controller can accept s_data this cycle.
REQ-010 core_in  output  64  word to the sha3_high_throughput core.
REQ-011 core_in_ready  output  1  one-cycle word strobe to the core.
REQ-012 core_is_last  output  1  marks the final word of the message.
REQ-013 core_byte_num  output  3  valid bytes in the final word; 0 means an empty final word.
REQ-014 core_buffer_full  input  1  core cannot take a word this cycle.
REQ-015 core_out  input  512  core digest.
REQ-016 core_out_ready  input  1  core digest valid.
REQ-017 digest  output  512  captured digest.
REQ-018 digest_valid  output  1  digest holds the result of the current message.
REQ-019 digest_ack  input  1  consumer has taken the digest.

Function
REQ-020 FSM states SHALL be IDLE, FEED, LAST, WAIT_OUT, DONE.
REQ-021 IDLE: start=1 SHALL latch nfull=msg_len>>3 and rem=msg_len[2:0], then go to FEED if nfull!=0, else to LAST.
REQ-022 start SHALL be ignored in every state except IDLE.
REQ-023 FEED: s_ready = !core_buffer_full; on s_valid&&s_ready, core_in=s_data, core_in_ready=1, core_is_last=0, and nfull decrements, all in the same cycle with zero latency.
REQ-024 FEED SHALL go to LAST on the handshake that brings nfull to 0.
REQ-025 LAST with rem!=0: s_ready = !core_buffer_full; on handshake, core_in=s_data, core_in_ready=1, core_is_last=1, core_byte_num=rem, then go to WAIT_OUT.
REQ-026 LAST with rem==0: s_ready=0; when !core_buffer_full, core_in=0, core_in_ready=1, core_is_last=1, core_byte_num=0, then go to WAIT_OUT.
REQ-027 Outside handshake cycles: core_in_ready=0, core_is_last=0, core_byte_num=0, core_in=0; s_ready=0 in IDLE, WAIT_OUT, DONE.
REQ-028 core_buffer_full=1 SHALL force s_ready=0 and core_in_ready=0 in that cycle; no word is lost or duplicated.
REQ-029 WAIT_OUT: core_out_ready=1 SHALL register digest<=core_out and set digest_valid=1 on the next edge; the FSM then enters DONE.
REQ-030 DONE: digest and digest_valid SHALL hold until digest_ack=1, which clears digest_valid and returns the FSM to IDLE; digest keeps its value.
REQ-031 core_out_ready outside WAIT_OUT SHALL be ignored.
REQ-032 Exactly nfull+1 core_in_ready pulses SHALL be issued per message, whatever the value of rem.
REQ-033 msg_len = 2^LEN_W-1 SHALL be handled without counter overflow; nfull uses LEN_W-3 bits.

Reset
REQ-034 reset=1 SHALL force IDLE, busy=0, s_ready=0, core_in_ready=0, core_is_last=0, core_byte_num=0, core_in=0, digest=0, digest_valid=0, nfull=0, rem=0, from any state including mid-message.
REQ-035 reset SHALL take priority over start, s_valid, core_out_ready and digest_ack in the same cycle.

Verification
REQ-036 msg_len=16, s_valid held high, buffer_full=0 -> two pulses with is_last=0, then one empty pulse with is_last=1, byte_num=0, core_in=0; s_ready low on the third pulse.
REQ-037 msg_len=13 -> one pulse with is_last=0, then one pulse with is_last=1, byte_num=5, core_in equal to the second s_data word.
REQ-038 msg_len=0 -> a single pulse with is_last=1, byte_num=0; no s_data consumed.
REQ-039 core_buffer_full held high for 3 cycles in FEED -> s_ready=0 and no pulse for those 3 cycles; feeding resumes with the same word.
REQ-040 core_out_ready pulse with core_out=X -> digest=X and digest_valid=1 the next cycle, held 5 cycles until digest_ack; start during DONE is ignored.
REQ-041 reset asserted mid-FEED after 1 of 4 words -> next cycle IDLE with all outputs 0; a following start with msg_len=8 completes normally.

Source files
------------

// File: rtl/sha3_feed_controller.sv
// sha3_feed_controller: splits a byte-length message into 64-bit words for a
// sha3_high_throughput core, tags the final (possibly empty) word with its
// byte count, then captures and holds the 512-bit digest until acknowledged.
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   start, msg_len    begin a message of msg_len bytes (accepted in IDLE only)
//   busy              high whenever the controller is not IDLE
//   s_data/s_valid/s_ready            upstream word stream (little-endian)
//   core_in/core_in_ready/core_is_last/core_byte_num  word strobe to core
//   core_buffer_full  core back-pressure
//   core_out/core_out_ready           digest from core
//   digest/digest_valid/digest_ack    captured digest to consumer
module sha3_feed_controller #(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_len,
  output logic             busy,
  input  logic [63:0]      s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [63:0]      core_in,
  output logic             core_in_ready,
  output logic             core_is_last,
  output logic [2:0]       core_byte_num,
  input  logic             core_buffer_full,
  input  logic [511:0]     core_out,
  input  logic             core_out_ready,
  output logic [511:0]     digest,
  output logic             digest_valid,
  input  logic             digest_ack
);

  localparam int unsigned NF_W = LEN_W - 3;

  typedef enum logic [2:0] {
    IDLE,
    FEED,
    LAST,
    WAIT_OUT,
    DONE
  } state_t;

  state_t          state, state_next;
  logic [NF_W-1:0] nfull, nfull_next;
  logic [2:0]      rem, rem_next;
  logic            capture;

  // Outputs are also held at zero while reset is asserted so that reset
  // dominates every other input within the same cycle.
  always_comb begin
    state_next    = state;
    nfull_next    = nfull;
    rem_next      = rem;
    s_ready       = 1'b0;
    core_in       = '0;
    core_in_ready = 1'b0;
    core_is_last  = 1'b0;
    core_byte_num = '0;
    capture       = 1'b0;
    busy          = 1'b0;

    if (!reset) begin
      busy = (state != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            nfull_next = msg_len[LEN_W-1:3];
            rem_next   = msg_len[2:0];
            state_next = (msg_len[LEN_W-1:3] != '0) ? FEED : LAST;
          end
        end

        FEED: begin
          s_ready = !core_buffer_full;
          if (s_valid && !core_buffer_full) begin
            core_in       = s_data;
            core_in_ready = 1'b1;
            nfull_next    = nfull - 1'b1;
            if (nfull == NF_W'(1)) state_next = LAST;
          end
        end

        LAST: begin
          if (rem != '0) begin
            s_ready = !core_buffer_full;
            if (s_valid && !core_buffer_full) begin
              core_in       = s_data;
              core_in_ready = 1'b1;
              core_is_last  = 1'b1;
              core_byte_num = rem;
              state_next    = WAIT_OUT;
            end
          end else if (!core_buffer_full) begin
            // Length is a multiple of 8: close the message with an empty word.
            core_in_ready = 1'b1;
            core_is_last  = 1'b1;
            state_next    = WAIT_OUT;
          end
        end

        WAIT_OUT: begin
          if (core_out_ready) begin
            capture    = 1'b1;
            state_next = DONE;
          end
        end

        DONE: begin
          if (digest_ack) state_next = IDLE;
        end

        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      nfull        <= '0;
      rem          <= '0;
      digest       <= '0;
      digest_valid <= 1'b0;
    end else begin
      state <= state_next;
      nfull <= nfull_next;
      rem   <= rem_next;
      if (capture) begin
        digest       <= core_out;
        digest_valid <= 1'b1;
      end else if (state == DONE && digest_ack) begin
        digest_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sha3_feed_controller.sv
module tb_sha3_feed_controller;

  localparam int unsigned LEN_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [LEN_W-1:0] msg_len;
  logic             busy;
  logic [63:0]      s_data;
  logic             s_valid;
  logic             s_ready;
  logic [63:0]      core_in;
  logic             core_in_ready;
  logic             core_is_last;
  logic [2:0]       core_byte_num;
  logic             core_buffer_full;
  logic [511:0]     core_out;
  logic             core_out_ready;
  logic [511:0]     digest;
  logic             digest_valid;
  logic             digest_ack;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [511:0] prev_digest;

  sha3_feed_controller #(.LEN_W(LEN_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .msg_len          (msg_len),
    .busy             (busy),
    .s_data           (s_data),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .core_in          (core_in),
    .core_in_ready    (core_in_ready),
    .core_is_last     (core_is_last),
    .core_byte_num    (core_byte_num),
    .core_buffer_full (core_buffer_full),
    .core_out         (core_out),
    .core_out_ready   (core_out_ready),
    .digest           (digest),
    .digest_valid     (digest_valid),
    .digest_ack       (digest_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] x;
    for (int i = 0; i < 16; i++) x[i*32 +: 32] = $urandom();
    return x;
  endfunction

  function automatic bit pct(input int unsigned p);
    return ($urandom_range(0, 99) < p);
  endfunction

  task automatic idle_inputs();
    start            = 1'b0;
    msg_len          = '0;
    s_valid          = 1'b0;
    s_data           = '0;
    core_buffer_full = 1'b0;
    core_out_ready   = 1'b0;
    core_out         = '0;
    digest_ack       = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_busy"},   busy, 0);
    chk({tag, "_sready"}, s_ready, 0);
    chk({tag, "_strobe"}, core_in_ready, 0);
    chk({tag, "_last"},   core_is_last, 0);
    chk({tag, "_bytes"},  core_byte_num, 0);
    chk({tag, "_corein"}, core_in, 0);
    chk({tag, "_dvalid"}, digest_valid, 0);
  endtask

  // Reference: a message of len bytes yields len/8 full words, then one final
  // word carrying len%8 bytes (taken from the stream only when len%8 != 0).
  task automatic run_msg(input int unsigned len, input int unsigned vpct,
                         input int unsigned fpct, input bit burst);
    int unsigned nf, rm, data_words, total, sent, cycles, budget;
    logic [63:0]  cur_word;
    logic [511:0] x;
    bit can_data, empty_last, exp_pulse, exp_last;

    nf         = len / 8;
    rm         = len % 8;
    data_words = nf + ((rm != 0) ? 1 : 0);
    total      = nf + 1;
    sent       = 0;
    cycles     = 0;
    budget     = total * 40 + 40;
    cur_word   = rand64();

    @(negedge clk);
    idle_inputs();
    start   = 1'b1;
    msg_len = LEN_W'(len);
    #1;
    chk("start_idle_busy", busy, 0);
    chk("start_idle_sready", s_ready, 0);

    while (sent < total && cycles < budget) begin
      @(negedge clk);
      start            = pct(50);
      msg_len          = LEN_W'($urandom());
      s_valid          = pct(vpct);
      s_data           = (sent < data_words) ? cur_word : rand64();
      core_buffer_full = (burst && cycles < 3) ? 1'b1 : pct(fpct);
      core_out_ready   = pct(30);
      core_out         = rand512();
      #1;
      can_data   = (sent < data_words);
      empty_last = !can_data && (sent < total);
      exp_pulse  = (can_data && s_valid && !core_buffer_full) ||
                   (empty_last && !core_buffer_full);
      exp_last   = exp_pulse && (sent == nf);
      chk("feed_busy",   busy, 1);
      chk("feed_sready", s_ready, can_data && !core_buffer_full);
      chk("feed_strobe", core_in_ready, exp_pulse);
      chk("feed_last",   core_is_last, exp_last);
      chk("feed_bytes",  core_byte_num, exp_last ? rm : 0);
      chk("feed_corein", core_in, (exp_pulse && can_data) ? cur_word : 64'd0);
      chk("feed_dvalid", digest_valid, 0);
      chk("feed_digest", digest, prev_digest);
      if (exp_pulse) begin
        sent++;
        if (can_data) cur_word = rand64();
      end
      cycles++;
    end
    chk("pulse_count", sent, total);

    @(negedge clk);
    idle_inputs();
    #1;
    chk("wait_busy",   busy, 1);
    chk("wait_sready", s_ready, 0);
    chk("wait_strobe", core_in_ready, 0);
    chk("wait_dvalid", digest_valid, 0);
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      #1;
      chk("wait_hold_dvalid", digest_valid, 0);
      chk("wait_hold_digest", digest, prev_digest);
    end

    x = rand512();
    @(negedge clk);
    core_out_ready = 1'b1;
    core_out       = x;
    #1;
    chk("cap_pre_dvalid", digest_valid, 0);

    repeat (5) begin
      @(negedge clk);
      core_out_ready = 1'b1;
      core_out       = rand512();
      start          = 1'b1;
      msg_len        = LEN_W'($urandom());
      #1;
      chk("done_digest", digest, x);
      chk("done_dvalid", digest_valid, 1);
      chk("done_busy",   busy, 1);
      chk("done_sready", s_ready, 0);
    end

    @(negedge clk);
    idle_inputs();
    digest_ack = 1'b1;
    start      = 1'b1;
    #1;
    chk("ack_dvalid", digest_valid, 1);

    @(negedge clk);
    idle_inputs();
    #1;
    chk("post_ack_busy",   busy, 0);
    chk("post_ack_dvalid", digest_valid, 0);
    chk("post_ack_digest", digest, x);
    prev_digest = x;
  endtask

  initial begin
    logic [63:0] w;

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_quiet("por");
    chk("por_digest", digest, 512'd0);
    prev_digest = '0;

    run_msg(16, 100, 0, 1'b0);
    run_msg(13, 100, 0, 1'b0);
    run_msg(0, 100, 0, 1'b0);
    run_msg(32, 100, 0, 1'b1);
    run_msg(21, 100, 0, 1'b1);
    for (int i = 0; i < 8; i++)
      run_msg($urandom_range(0, 80), 60, 30, 1'b0);

    // Abort a four-word message after its first word.
    @(negedge clk);
    idle_inputs();
    start   = 1'b1;
    msg_len = LEN_W'(32);
    @(negedge clk);
    idle_inputs();
    w       = rand64();
    s_valid = 1'b1;
    s_data  = w;
    #1;
    chk("abort_strobe", core_in_ready, 1);
    chk("abort_corein", core_in, w);
    @(negedge clk);
    reset          = 1'b1;
    start          = 1'b1;
    msg_len        = LEN_W'(8);
    digest_ack     = 1'b1;
    core_out_ready = 1'b1;
    core_out       = rand512();
    s_valid        = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    #1;
    check_quiet("abort");
    chk("abort_digest", digest, 512'd0);
    prev_digest = '0;

    run_msg(8, 100, 0, 1'b0);
    run_msg(65535, 100, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
